// File: rtl/sysid_ext_qsys.sv
// sysid_ext_qsys: Avalon-MM system ID block with control, status, 64-bit uptime counter and scratch registers
// Ports: clock/reset (sync, active-high); address/read/write/writedata/byteenable slave inputs;
// readdata/readdatavalid registered read response, fixed latency 1, no waitrequest.
module sysid_ext_qsys #(
  parameter logic [31:0] SYSID_VALUE = 32'h6390_7B71,
  parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
  parameter int          NUM_SCRATCH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);
  localparam logic [3:0] NS = 4'(NUM_SCRATCH);
  logic [31:0] r_readdata;
  logic        r_readdatavalid;
  logic        r_en;
  logic [63:0] r_uptime;
  logic [31:0] r_hi_snap;
  logic        r_snap_valid;
  logic [31:0] r_scratch [8];
  logic        w_wr;
  logic        w_ctl_wr;
  logic        w_clr;
  logic        w_lo_rd;
  logic        w_scr_hit;
  logic [2:0]  w_idx;
  logic [31:0] w_rdata;
  // a simultaneous read wins, so the write is dropped
  assign w_wr      = write & ~read;
  assign w_ctl_wr  = w_wr & (address == 4'd2) & byteenable[0];
  assign w_clr     = w_ctl_wr & writedata[1];
  assign w_lo_rd   = read & (address == 4'd4);
  assign w_idx     = address[2:0];
  // scratch slots at or beyond NUM_SCRATCH behave as unmapped
  assign w_scr_hit = address[3] & ({1'b0, w_idx} < NS);
  always_comb begin
    w_rdata = '0;
    case (address)
      4'd0:    w_rdata = SYSID_VALUE;
      4'd1:    w_rdata = TIMESTAMP;
      4'd2:    w_rdata = {31'd0, r_en};
      4'd3:    w_rdata = {20'd0, NS, 7'd0, r_snap_valid};
      4'd4:    w_rdata = r_uptime[31:0];
      4'd5:    w_rdata = r_hi_snap;
      default: w_rdata = w_scr_hit ? r_scratch[w_idx] : '0;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
      r_en            <= 1'b1;
      r_uptime        <= '0;
      r_hi_snap       <= '0;
      r_snap_valid    <= 1'b0;
      for (int i = 0; i < 8; i++) r_scratch[i] <= '0;
    end else begin
      r_readdatavalid <= read;
      if (read) r_readdata <= w_rdata;
      // CLR loads zero at this edge; the newly written EN governs counting from the next edge
      r_uptime <= w_clr ? '0 : r_uptime + 64'(r_en);
      if (w_ctl_wr) r_en <= writedata[0];
      // the HI half is snapshotted with the LO read so a later carry cannot tear the 64-bit value
      if (w_clr) begin
        r_hi_snap    <= '0;
        r_snap_valid <= 1'b0;
      end else if (w_lo_rd) begin
        r_hi_snap    <= r_uptime[63:32];
        r_snap_valid <= 1'b1;
      end
      for (int k = 0; k < 4; k++)
        if (w_wr && w_scr_hit && byteenable[k]) r_scratch[w_idx][8*k +: 8] <= writedata[8*k +: 8];
    end
  end
  assign readdata      = r_readdata;
  assign readdatavalid = r_readdatavalid;
endmodule

// File: tb/tb_sysid_ext_qsys.sv
// tb_sysid_ext_qsys: randomized and directed check of sysid_ext_qsys against a behavioural register-map model
module tb_sysid_ext_qsys;
  localparam int          NS  = 4;
  localparam logic [31:0] ID  = 32'h6390_7B71;
  localparam logic [31:0] TS  = 32'h1234_5678;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;
  int checks = 0;
  int errors = 0;
  bit [63:0] m_up;
  bit        m_en;
  bit        m_sv;
  bit [31:0] m_hi;
  bit [31:0] m_scr [NS];
  bit [31:0] m_rd;
  bit        m_v;
  sysid_ext_qsys #(.TIMESTAMP(TS), .NUM_SCRATCH(NS)) dut (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata), .readdatavalid(readdatavalid)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask
  function automatic bit [31:0] m_read(input int a);
    if (a == 0) return ID;
    if (a == 1) return TS;
    if (a == 2) return {31'd0, m_en};
    if (a == 3) return 32'(NS) << 8 | 32'(m_sv);
    if (a == 4) return m_up[31:0];
    if (a == 5) return m_hi;
    if (a >= 8 && a < 8 + NS) return m_scr[a-8];
    return 0;
  endfunction
  task automatic step(input bit rst, input bit rd, input bit wr, input int a, input bit [31:0] wd, input bit [3:0] be);
    bit wr_ok;
    reset = rst; read = rd; write = wr; address = 4'(a); writedata = wd; byteenable = be;
    @(posedge clock);
    wr_ok = wr && !rd;
    if (rst) begin
      m_v = 0; m_rd = 0; m_en = 1; m_up = 0; m_hi = 0; m_sv = 0;
      foreach (m_scr[i]) m_scr[i] = 0;
    end else begin
      m_v = rd;
      if (rd) m_rd = m_read(a);
      if (rd && a == 4) begin m_hi = m_up[63:32]; m_sv = 1; end
      if (wr_ok && a == 2 && be[0] && wd[1]) begin
        m_up = 0; m_hi = 0; m_sv = 0;
      end else if (m_en) m_up = m_up + 1;
      if (wr_ok && a == 2 && be[0]) m_en = wd[0];
      if (wr_ok && a >= 8 && a < 8 + NS)
        for (int k = 0; k < 4; k++) if (be[k]) m_scr[a-8][8*k +: 8] = wd[8*k +: 8];
    end
    @(negedge clock);
    chk($sformatf("rdv a%0d", a), {31'd0, readdatavalid}, {31'd0, m_v});
    chk($sformatf("rdata a%0d", a), readdata, m_rd);
    reset = 0; read = 0; write = 0;
  endtask
  initial begin
    @(negedge clock);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("id", readdata, ID);
    step(0, 1, 0, 1, 0, 0);
    chk("ts", readdata, TS);
    step(0, 0, 1, 9, 32'hDEAD_BEEF, 4'b0101);
    step(0, 1, 0, 9, 0, 0);
    chk("scr9", readdata, 32'h00AD_00EF);
    step(0, 1, 0, 14, 0, 0);
    chk("unmapped14", readdata, 32'h0);
    step(0, 0, 1, 8, 32'h1122_3344, 4'hF);
    step(0, 1, 1, 8, 32'hFFFF_FFFF, 4'hF);
    chk("rw8 old", readdata, 32'h1122_3344);
    step(0, 1, 0, 8, 0, 0);
    chk("rw8 kept", readdata, 32'h1122_3344);
    step(0, 0, 1, 2, 32'h0, 4'h1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 4, 0, 0);
    step(0, 1, 0, 4, 0, 0);
    step(0, 0, 1, 2, 32'h3, 4'h1);
    step(0, 1, 0, 3, 0, 0);
    chk("status after clr", readdata, 32'h0000_0400);
    step(0, 1, 0, 4, 0, 0);
    chk("lo small", {31'd0, readdata <= 32'd3}, 32'd1);
    step(0, 0, 1, 2, 32'h0, 4'h1);
    force dut.r_uptime = 64'h0000_0001_FFFF_FFFF;
    m_up = 64'h0000_0001_FFFF_FFFF;
    step(0, 0, 0, 0, 0, 0);
    release dut.r_uptime;
    step(0, 0, 1, 2, 32'h1, 4'h1);
    step(0, 1, 0, 4, 0, 0);
    chk("lo carry", readdata, 32'hFFFF_FFFF);
    step(0, 1, 0, 5, 0, 0);
    chk("hi snap", readdata, 32'h0000_0001);
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           $urandom_range(0, 15), $urandom, 4'($urandom));
    step(0, 0, 1, 10, 32'hCAFE_F00D, 4'hF);
    step(0, 1, 0, 4, 0, 0);
    step(1, 1, 0, 4, 0, 0);
    chk("rst rdv", {31'd0, readdatavalid}, 32'd0);
    for (int a = 0; a < 16; a++) step(0, 1, 0, a, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sysid_ext_qsys.md
SYSID_EXT_QSYS -- requirements
Module: sysid_ext_qsys

Interface
REQ-001 SHALL have parameter SYSID_VALUE, default 32'h6390_7B71, the system ID word.
REQ-002 SHALL have parameter TIMESTAMP, default 32'h0000_0000, the build timestamp word.
REQ-003 SHALL have parameter NUM_SCRATCH, default 4, the number of scratch registers (legal 1..8).
REQ-004 SHALL have port clock  in  1  the single clock; all logic rising-edge.
REQ-005 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port address  in  4  Avalon-MM word address.
REQ-007 SHALL have port read  in  1  read strobe.
REQ-008 SHALL have port write  in  1  write strobe.
REQ-009 SHALL have port writedata  in  32  write data.
REQ-010 SHALL have port byteenable  in  4  write byte lanes.
REQ-011 SHALL have port readdata  out  32  registered read data.
REQ-012 SHALL have port readdatavalid  out  1  read data qualifier.

Function
REQ-013 SHALL decode the word map: 0 ID (RO); 1 TIMESTAMP (RO); 2 CONTROL (RW); 3 STATUS (RO); 4 UPTIME_LO (RO); 5 UPTIME_HI_SNAP (RO); 8..8+NUM_SCRATCH-1 SCRATCH (RW); all other addresses unmapped.
REQ-014 SHALL have no waitrequest; every access completes in the cycle it is presented.
REQ-015 SHALL give fixed read latency 1: read at edge N -> readdata valid and readdatavalid=1 for exactly the cycle after edge N; readdatavalid=0 otherwise.
REQ-016 SHALL hold readdata at its last value when readdatavalid=0.
REQ-017 SHALL return 0 on reads of unmapped addresses and ignore writes to unmapped or RO addresses.
REQ-018 SHALL, when read and write are both asserted, perform the read only; the write is dropped.
REQ-019 SHALL implement CONTROL bit0 EN (RW), bit1 CLR (write-1, self-clearing, reads 0); bits 31:2 read 0; CONTROL writes honour byteenable[0] only.
REQ-020 SHALL maintain a 64-bit UPTIME counter incrementing by 1 per clock while EN=1, holding while EN=0.
REQ-021 SHALL wrap UPTIME from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag.
REQ-022 SHALL, on a CONTROL write with CLR=1, load UPTIME=0 at that edge (CLR overrides increment) and continue counting from 0 next cycle if the written EN=1.
REQ-023 SHALL, on a read of UPTIME_LO, return UPTIME[31:0] and capture UPTIME[63:32] into the HI snapshot at the same edge (coherent 64-bit read).
REQ-024 SHALL return the HI snapshot on UPTIME_HI_SNAP reads, unchanged until the next UPTIME_LO read, CLR, or reset.
REQ-025 SHALL set STATUS bit0 SNAP_VALID on an UPTIME_LO read and clear it on CLR or reset; STATUS bits 11:8 = NUM_SCRATCH; others 0.
REQ-026 SHALL clear the HI snapshot to 0 on CLR.
REQ-027 SHALL write SCRATCH registers per byte lane: byte k updated only if byteenable[k]=1.
REQ-028 SHALL treat scratch addresses at or beyond 8+NUM_SCRATCH as unmapped.

Reset
REQ-029 SHALL, while reset=1 at an edge, set readdata=0, readdatavalid=0, EN=1, UPTIME=0, HI snapshot=0, SNAP_VALID=0, all SCRATCH=0.
REQ-030 SHALL ignore read/write presented in a reset cycle; a read accepted the cycle before reset produces no readdatavalid once reset is sampled.
REQ-031 SHALL start counting on the first edge after reset deasserts (UPTIME=1 after that edge).

Verification
REQ-032 SHALL pass: reset, read addr 0 then addr 1 -> readdata 32'h6390_7B71 then TIMESTAMP, each with readdatavalid one cycle after read.
REQ-033 SHALL pass: write addr 9 data 32'hDEAD_BEEF be=4'b0101, read addr 9 -> 32'h00AD_00EF; read addr 14 (NUM_SCRATCH=4) -> 0.
REQ-034 SHALL pass: force UPTIME to 64'h0000_0001_FFFF_FFFF via counting/hierarchy, read addr 4 then addr 5 -> low word 32'hFFFF_FFFF, hi snapshot 32'h0000_0001 despite carry.
REQ-035 SHALL pass: write CONTROL 32'h0 (EN=0), wait 10 cycles, two LO reads -> equal values; write 32'h3 -> next LO read small (<=3), STATUS bit0=0 before any LO read.
REQ-036 SHALL pass: assert reset mid-run with read asserted on the same edge -> readdatavalid stays 0, all registers at REQ-029 values.
REQ-037 SHALL pass: read and write to addr 8 in the same cycle -> old scratch value returned, scratch unchanged.
